store_lane_queue: RTL and testbench

- Store-side byte-lane formatter and buffer. Sits directly upstream of the byte-enabled 32-bit write register.
- Accepts store requests (address, size, data) through a valid/ready handshake and rejects misaligned requests.
- Queues accepted requests, then drains one per cycle as RegWrEn, Enable0..3 and lane-replicated WriteData0, which feed the write register's ports of the same names.

---
 rtl/store_lane_queue_if.sv | 45 ++++
 rtl/store_lane_queue.sv | 163 ++++++++++++++++
 tb/tb_store_lane_queue.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_lane_queue_if.sv
// store_lane_queue_if
//   Bundles the store-request channel and the downstream write-register
//   channel of store_lane_queue.
//
//   Request channel (producer -> queue):
//     InValid, InAddr, InSize, InData  driven by the producer
//     InReady                          driven by the queue
//   Write channel (queue -> byte-enabled write register):
//     RegWrEn, Enable0..3, WriteData0, WrAddr  driven by the queue
//     Stall                                    driven by the register side
//
//   Handshake: a request transfers on a rising edge where InValid and
//   InReady are both high. The producer keeps InValid high and the payload
//   stable until that edge. InReady does not depend on InValid.
//
//   Modports: slave = the queue, master = the producer/consumer side.
interface store_lane_queue_if #(
    parameter int ADDR_W = 32
);
    logic              InValid;
    logic              InReady;
    logic [ADDR_W-1:0] InAddr;
    logic [1:0]        InSize;
    logic [31:0]       InData;
    logic              Stall;
    logic              RegWrEn;
    logic              Enable0;
    logic              Enable1;
    logic              Enable2;
    logic              Enable3;
    logic [31:0]       WriteData0;
    logic [ADDR_W-1:0] WrAddr;

    modport slave (
        input  InValid, InAddr, InSize, InData, Stall,
        output InReady, RegWrEn, Enable0, Enable1, Enable2, Enable3,
               WriteData0, WrAddr
    );

    modport master (
        output InValid, InAddr, InSize, InData, Stall,
        input  InReady, RegWrEn, Enable0, Enable1, Enable2, Enable3,
               WriteData0, WrAddr
    );
endinterface

// File: rtl/store_lane_queue.sv
// store_lane_queue
//   Store-side byte-lane formatter and buffer in front of the byte-enabled
//   32-bit write register. Requests are checked for alignment, formatted
//   into lane enables plus lane-replicated data, queued, and drained one per
//   cycle onto the register's write port.
//
//   Ports:
//     Clk           rising-edge clock
//     ResetBar      synchronous active-low reset
//     Flush         discard all queued stores (below reset in priority)
//     bus           request + write channels (store_lane_queue_if.slave)
//     AlignErr      one-cycle pulse after a rejected (misaligned) request
//     AlignErrAddr  address of the last rejected request
//     Count         occupied entries
//     Empty, Full   Count==0 / Count==DEPTH
module store_lane_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32
) (
    input  logic               Clk,
    input  logic               ResetBar,
    input  logic               Flush,
    store_lane_queue_if.slave  bus,
    output logic               AlignErr,
    output logic [ADDR_W-1:0]  AlignErrAddr,
    output logic [PTR_W:0]     Count,
    output logic               Empty,
    output logic               Full
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

    // Entry storage: word-aligned address, lane enables, formatted data.
    logic [ADDR_W-1:0] memAddr [DEPTH];
    logic [3:0]        memEn   [DEPTH];
    logic [31:0]       memData [DEPTH];

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    logic              misaligned;
    logic [3:0]        fmtEn;
    logic [31:0]       fmtData;
    logic              take;
    logic              push;
    logic              reject;
    logic              drain;

    logic              regWrEn;
    logic [3:0]        laneEn;
    logic [31:0]       wrData;
    logic [ADDR_W-1:0] wrAddr;

    assign Empty       = (Count == '0);
    assign Full        = (Count == FullCnt);
    // No bypass when full: a same-cycle drain does not open the input.
    assign bus.InReady = ResetBar & ~Full;

    // Alignment check and lane formatting of the incoming request.
    always_comb begin
        misaligned = 1'b0;
        fmtEn      = 4'b0000;
        fmtData    = 32'h0;
        case (bus.InSize)
            2'b00: begin
                fmtEn   = 4'b0001 << bus.InAddr[1:0];
                fmtData = {4{bus.InData[7:0]}};
            end
            2'b01: begin
                misaligned = bus.InAddr[0];
                fmtEn      = bus.InAddr[1] ? 4'b1100 : 4'b0011;
                fmtData    = {2{bus.InData[15:0]}};
            end
            2'b10: begin
                misaligned = |bus.InAddr[1:0];
                fmtEn      = 4'b1111;
                fmtData    = bus.InData;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // A rejected request is still consumed (handshake completes) but never
    // touches the queue, so it cannot reorder later stores.
    assign take   = bus.InValid & bus.InReady & ~Flush;
    assign push   = take & ~misaligned;
    assign reject = take & misaligned;
    assign drain  = ~Empty & ~bus.Stall & ~Flush;

    // Entry payload; validity is tracked by the pointers, so no reset here.
    always_ff @(posedge Clk) begin
        if (push) begin
            memAddr[wrPtr] <= {bus.InAddr[ADDR_W-1:2], 2'b00};
            memEn[wrPtr]   <= fmtEn;
            memData[wrPtr] <= fmtData;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (!ResetBar) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else if (Flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (drain) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, drain})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    // Registered write port and alignment-error reporting.
    always_ff @(posedge Clk) begin
        if (!ResetBar) begin
            regWrEn      <= 1'b0;
            laneEn       <= 4'b0000;
            wrData       <= 32'h0;
            wrAddr       <= '0;
            AlignErr     <= 1'b0;
            AlignErrAddr <= '0;
        end else if (Flush) begin
            regWrEn  <= 1'b0;
            laneEn   <= 4'b0000;
            AlignErr <= 1'b0;
        end else begin
            regWrEn  <= drain;
            laneEn   <= drain ? memEn[rdPtr] : 4'b0000;
            AlignErr <= reject;
            // Data and address hold their last values between drains.
            if (drain) begin
                wrData <= memData[rdPtr];
                wrAddr <= memAddr[rdPtr];
            end
            if (reject) begin
                AlignErrAddr <= bus.InAddr;
            end
        end
    end

    assign bus.RegWrEn    = regWrEn;
    assign bus.Enable0    = laneEn[0];
    assign bus.Enable1    = laneEn[1];
    assign bus.Enable2    = laneEn[2];
    assign bus.Enable3    = laneEn[3];
    assign bus.WriteData0 = wrData;
    assign bus.WrAddr     = wrAddr;

endmodule

// File: tb/tb_store_lane_queue.sv
module tb_store_lane_queue;

    logic        Clk;
    logic        ResetBar;
    logic        Flush;
    logic        AlignErr;
    logic [31:0] AlignErrAddr;
    logic [2:0]  Count;
    logic        Empty;
    logic        Full;

    store_lane_queue_if #(.ADDR_W(32)) bus ();

    store_lane_queue #(.DEPTH(4), .PTR_W(2), .ADDR_W(32)) dut (
        .Clk          (Clk),
        .ResetBar     (ResetBar),
        .Flush        (Flush),
        .bus          (bus.slave),
        .AlignErr     (AlignErr),
        .AlignErrAddr (AlignErrAddr),
        .Count        (Count),
        .Empty        (Empty),
        .Full         (Full)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic monOn = 1'b0;
    // Scoreboard entry: {WrAddr, enables[3:0], WriteData0}
    logic [67:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lanes();
        return {bus.Enable3, bus.Enable2, bus.Enable1, bus.Enable0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        bus.InValid = v;
        bus.InAddr  = a;
        bus.InSize  = s;
        bus.InData  = d;
    endtask

    // ---------------- drain monitor / scoreboard ----------------
    always @(negedge Clk) begin
        if (monOn && bus.RegWrEn) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected actual=%0h expected=none", bus.WrAddr);
            end else begin
                logic [67:0] e;
                logic [67:0] got;
                e   = exp_q.pop_front();
                got = {bus.WrAddr, lanes(), bus.WriteData0};
                if (got !== e) begin
                    errors++;
                    $display("FAIL drain_order actual=%0h expected=%0h", got, e);
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic        expErr;
        logic [3:0]  expEn;
        logic [31:0] expData;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h0000_1003, 2'b00, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0000_1000};
        vecs[1]  = '{32'h0000_2002, 2'b01, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234, 32'h0000_2000};
        vecs[2]  = '{32'h0000_3000, 2'b10, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_3000};
        vecs[3]  = '{32'h0000_4001, 2'b10, 32'h1111_1111, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[4]  = '{32'h0000_5001, 2'b01, 32'h0000_2222, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{32'h0000_6000, 2'b11, 32'h3333_3333, 1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[6]  = '{32'h0000_7000, 2'b00, 32'h0000_01C5, 1'b0, 4'b0001, 32'hC5C5_C5C5, 32'h0000_7000};
        vecs[7]  = '{32'h0000_8000, 2'b01, 32'hFFFF_CAFE, 1'b0, 4'b0011, 32'hCAFE_CAFE, 32'h0000_8000};
        vecs[8]  = '{32'h0000_9001, 2'b00, 32'h0000_005A, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0000_9000};
        vecs[9]  = '{32'h0000_9002, 2'b00, 32'h0000_0077, 1'b0, 4'b0100, 32'h7777_7777, 32'h0000_9000};
        vecs[10] = '{32'h0000_A006, 2'b10, 32'h1234_5678, 1'b1, 4'b0000, 32'h0,         32'h0};
    end

    // ---------------- main sequence ----------------
    initial begin
        ResetBar  = 1'b0;
        Flush     = 1'b0;
        bus.Stall = 1'b0;
        drive_req(1'b1, 32'h0000_0100, 2'b10, 32'h5555_5555);

        // Reset held for two edges with a request pending.
        step();
        step();
        check("rst_inready", 64'(bus.InReady), 64'd0);
        check("rst_count", 64'(Count), 64'd0);
        check("rst_regwren", 64'(bus.RegWrEn), 64'd0);
        check("rst_empty", 64'(Empty), 64'd1);
        check("rst_wdata", 64'(bus.WriteData0), 64'd0);
        check("rst_alignaddr", 64'(AlignErrAddr), 64'd0);
        ResetBar = 1'b1;
        drive_req(1'b0, 32'h0, 2'b00, 32'h0);
        #1;
        check("rst_release_inready", 64'(bus.InReady), 64'd1);

        // Table: one request, then idle one cycle to see its drain.
        for (int i = 0; i < 11; i++) begin
            drive_req(1'b1, vecs[i].addr, vecs[i].size, vecs[i].data);
            step();
            drive_req(1'b0, 32'h0, 2'b00, 32'h0);
            check($sformatf("v%0d_alignerr", i), 64'(AlignErr), 64'(vecs[i].expErr));
            check($sformatf("v%0d_count", i), 64'(Count), vecs[i].expErr ? 64'd0 : 64'd1);
            if (vecs[i].expErr)
                check($sformatf("v%0d_alignaddr", i), 64'(AlignErrAddr), 64'(vecs[i].addr));
            step();
            check($sformatf("v%0d_alignerr_pulse", i), 64'(AlignErr), 64'd0);
            check($sformatf("v%0d_regwren", i), 64'(bus.RegWrEn), vecs[i].expErr ? 64'd0 : 64'd1);
            check($sformatf("v%0d_enables", i), 64'(lanes()), 64'(vecs[i].expEn));
            if (!vecs[i].expErr) begin
                check($sformatf("v%0d_wdata", i), 64'(bus.WriteData0), 64'(vecs[i].expData));
                check($sformatf("v%0d_wraddr", i), 64'(bus.WrAddr), 64'(vecs[i].expAddr));
            end
            check($sformatf("v%0d_empty", i), 64'(Empty), 64'd1);
        end

        // Full and wrap, three rounds.
        monOn = 1'b1;
        for (int r = 0; r < 3; r++) begin
            bus.Stall = 1'b1;
            for (int k = 0; k < 4; k++) begin
                logic [31:0] a;
                logic [31:0] d;
                a = 32'h0001_0000 + 32'(r * 256 + k * 4);
                d = 32'hA000_0000 + 32'(r * 16 + k);
                drive_req(1'b1, a, 2'b10, d);
                exp_q.push_back({a, 4'b1111, d});
                step();
            end
            check($sformatf("r%0d_full", r), 64'(Full), 64'd1);
            check($sformatf("r%0d_inready", r), 64'(bus.InReady), 64'd0);
            drive_req(1'b1, 32'h0002_0000, 2'b10, 32'hBAD0_BAD0);
            step();
            check($sformatf("r%0d_held_count", r), 64'(Count), 64'd4);
            check($sformatf("r%0d_stall_regwren", r), 64'(bus.RegWrEn), 64'd0);
            drive_req(1'b0, 32'h0, 2'b00, 32'h0);
            bus.Stall = 1'b0;
            for (int k = 0; k < 4; k++) begin
                step();
                check($sformatf("r%0d_drain%0d", r, k), 64'(bus.RegWrEn), 64'd1);
            end
            check($sformatf("r%0d_empty", r), 64'(Empty), 64'd1);
            step();
            check($sformatf("r%0d_idle_regwren", r), 64'(bus.RegWrEn), 64'd0);
        end

        // Streaming, one per cycle.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'h0003_0000 + 32'(k * 4);
            d = 32'hC000_0000 + 32'(k);
            drive_req(1'b1, a, 2'b10, d);
            exp_q.push_back({a, 4'b1111, d});
            step();
            check($sformatf("s%0d_count", k), 64'(Count), 64'd1);
            check($sformatf("s%0d_regwren", k), 64'(bus.RegWrEn), (k == 0) ? 64'd0 : 64'd1);
        end
        drive_req(1'b0, 32'h0, 2'b00, 32'h0);
        step();
        check("stream_tail_empty", 64'(Empty), 64'd1);

        // Stall toggling every other cycle while requests keep coming.
        for (int k = 0; k < 12; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'h0004_0000 + 32'(k * 4);
            d = 32'hD000_0000 + 32'($urandom_range(0, 65535));
            bus.Stall = ((k / 2) % 2 == 1);
            drive_req(1'b1, a, 2'b10, d);
            if (bus.InReady) exp_q.push_back({a, 4'b1111, d});
            step();
        end
        drive_req(1'b0, 32'h0, 2'b00, 32'h0);
        bus.Stall = 1'b0;
        begin
            int budget;
            budget = 0;
            while (!Empty && budget < 10) begin
                step();
                budget++;
            end
            check("toggle_drain_done", 64'(Empty), 64'd1);
        end
        step();
        check("toggle_no_loss", 64'(exp_q.size()), 64'd0);
        monOn = 1'b0;

        // Flush with three queued and a request presented.
        bus.Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_req(1'b1, 32'h0005_0000 + 32'(k * 4), 2'b10, 32'hE000_0000 + 32'(k));
            step();
        end
        check("flush_pre_count", 64'(Count), 64'd3);
        Flush = 1'b1;
        drive_req(1'b1, 32'h0005_0100, 2'b10, 32'hEEEE_EEEE);
        step();
        Flush = 1'b0;
        drive_req(1'b0, 32'h0, 2'b00, 32'h0);
        check("flush_count", 64'(Count), 64'd0);
        check("flush_regwren", 64'(bus.RegWrEn), 64'd0);
        Flush = 1'b1;
        drive_req(1'b1, 32'h0005_0203, 2'b10, 32'hEEEE_EEEE);
        step();
        Flush = 1'b0;
        drive_req(1'b0, 32'h0, 2'b00, 32'h0);
        check("flush_no_alignerr", 64'(AlignErr), 64'd0);
        check("flush_alignaddr_hold", 64'(AlignErrAddr), 64'h0000_A006);
        bus.Stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("flush_nodrain%0d", k), 64'(bus.RegWrEn), 64'd0);
        end

        // Refill, then a one-cycle reset mid-drain.
        drive_req(1'b1, 32'h0006_0000, 2'b10, 32'h6666_6666);
        step();
        drive_req(1'b1, 32'h0006_0004, 2'b10, 32'h7777_7777);
        step();
        check("refill_regwren", 64'(bus.RegWrEn), 64'd1);
        ResetBar = 1'b0;
        #1;
        check("mid_rst_inready", 64'(bus.InReady), 64'd0);
        step();
        ResetBar = 1'b1;
        drive_req(1'b0, 32'h0, 2'b00, 32'h0);
        check("mid_rst_count", 64'(Count), 64'd0);
        check("mid_rst_regwren", 64'(bus.RegWrEn), 64'd0);
        check("mid_rst_enables", 64'(lanes()), 64'd0);
        check("mid_rst_wdata", 64'(bus.WriteData0), 64'd0);
        check("mid_rst_wraddr", 64'(bus.WrAddr), 64'd0);
        check("mid_rst_alignaddr", 64'(AlignErrAddr), 64'd0);
        check("mid_rst_alignerr", 64'(AlignErr), 64'd0);
        step();
        check("post_rst_nodrain", 64'(bus.RegWrEn), 64'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
